mod_step_counter: RTL

Parametrised up/down counter with programmable upper limit, variable step, synchronous load/clear and three boundary modes: wrap, saturate and one-shot. It is the general-purpose successor to the fixed-step free-running counter. It serves timers, address generators and event counters that need a runtime-programmable range and a terminal-count indication.

---
 rtl/mod_step_counter.sv | 95 +++++++++
 1 files changed

// File: rtl/mod_step_counter.sv
// Up/down counter with programmable inclusive limit, variable step and
// wrap / saturate / one-shot boundary handling with a registered terminal-count pulse.
module mod_step_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              en,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic [1:0]        mode,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              done,
  output logic              at_limit,
  output logic              at_zero
);

  // One bit wider than the widest operand so the up-sum never truncates.
  localparam int AW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;

  logic [AW-1:0]    count_x, step_x, limit_x, sum;
  logic [WIDTH-1:0] diff;
  logic             step_nz, overflow, underflow, boundary;

  assign count_x   = {{(AW-WIDTH){1'b0}}, count};
  assign step_x    = {{(AW-STEP_W){1'b0}}, step};
  assign limit_x   = {{(AW-WIDTH){1'b0}}, limit};
  assign sum       = count_x + step_x;
  // Only consumed when step <= count, so the result fits in WIDTH bits.
  assign diff      = WIDTH'(count_x - step_x);
  assign step_nz   = (step != '0);
  assign overflow  = up_down && (sum > limit_x);
  assign underflow = !up_down && (step_x > count_x);
  assign boundary  = step_nz && (overflow || underflow);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    tc_nxt    = 1'b0;
    if (clr) begin
      count_nxt = '0;
      state_nxt = ST_RUN;
    end else if (load) begin
      count_nxt = (load_val > limit) ? limit : load_val;
      state_nxt = ST_RUN;
    end else if (en && (state == ST_RUN) && step_nz) begin
      if (boundary) begin
        tc_nxt = 1'b1;
        case (mode)
          2'b01: count_nxt = up_down ? limit : '0;
          2'b10: begin
            count_nxt = up_down ? limit : '0;
            state_nxt = ST_DONE;
          end
          default: count_nxt = up_down ? '0 : limit;
        endcase
      end else begin
        count_nxt = up_down ? sum[WIDTH-1:0] : diff;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      count <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      tc    <= tc_nxt;
    end
  end

  // done doubles as the state observation point for the two-state FSM.
  assign done     = (state == ST_DONE);
  assign at_limit = (count == limit);
  assign at_zero  = (count == '0);

endmodule
